// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// The encoder is also the bench's reference for gnt_idx.
package arb_pkg;

   localparam int NREQ  = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // One-hot (or zero) to binary index; zero maps to index 0.
   function automatic logic [IDX_W-1:0] onehot2idx(input logic [NREQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      case (oh)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotated priority encoder: the first set request scanning ptr, ptr+1, ... (mod 4).
// Rotate so ptr lands at bit 0, fixed-priority encode, then add ptr back.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] win_idx
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [IDX_W-1:0]  off;

   assign dbl = {req, req};
   assign rot = dbl[ptr +: NREQ];

   always_comb begin
      off = '0;
      if (rot[0])      off = 2'd0;
      else if (rot[1]) off = 2'd1;
      else if (rot[2]) off = 2'd2;
      else if (rot[3]) off = 2'd3;
   end

   assign any     = |req;
   assign win_idx = off + ptr;

endmodule

// File: rtl/rr_arbiter4_enc.sv
// Four-requester round-robin arbiter with registered one-hot grant, encoded index
// and a MAX_HOLD tenure timeout that preempts a holder while others are waiting.
module rr_arbiter4_enc
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt
);

   // With preemption disabled the counter simply saturates at all-ones.
   localparam logic [HOLD_W-1:0] HOLD_SAT =
      (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

   arb_state_t       state;
   logic [IDX_W-1:0] ptr;
   logic [HOLD_W-1:0] hold_cnt;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic             holder_req;
   logic             others_req;
   logic             timeout;

   rr_pick4 u_pick (
      .req     (req),
      .ptr     (ptr),
      .any     (pick_any),
      .win_idx (pick_idx)
   );

   assign holder_req = req[gnt_idx];
   assign others_req = |(req & ~gnt);
   assign timeout    = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT) && others_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB_IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         gnt_idx  <= '0;
         preempt  <= 1'b0;
      end else begin
         preempt <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  state    <= ARB_BUSY;
                  gnt      <= idx2onehot(pick_idx);
                  gnt_idx  <= pick_idx;
                  ptr      <= pick_idx + 2'd1;
                  hold_cnt <= '0;
               end
            end
            ARB_BUSY: begin
               // Release wins over timeout, so a holder dropping in its last cycle is not preempted.
               if (!holder_req) begin
                  state   <= ARB_IDLE;
                  gnt     <= '0;
                  gnt_idx <= '0;
               end else if (timeout) begin
                  state   <= ARB_IDLE;
                  gnt     <= '0;
                  gnt_idx <= '0;
                  preempt <= 1'b1;
               end else if (hold_cnt != HOLD_SAT) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state   <= ARB_IDLE;
               gnt     <= '0;
               gnt_idx <= '0;
            end
         endcase
      end
   end

   assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_arbiter4_enc.sv
// Directed bench for rr_arbiter4_enc: cycle-accurate vector table plus
// hand-written preempt, long-hold and reset sequences, with per-cycle invariants.
module tb_rr_arbiter4_enc;
   import arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;

   int total = 0;
   int bad   = 0;
   bit inv_on = 1'b0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic       pre;
   } vec_t;

   vec_t tbl[$];

   rr_arbiter4_enc #(.MAX_HOLD(8), .HOLD_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g, input logic p);
      vec_t v;
      v.rst = r;
      v.req = q;
      v.gnt = g;
      v.pre = p;
      tbl.push_back(v);
   endtask

   task automatic check(input string nm, input int n, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", nm, n, act, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge sample them, then compare outputs.
   task automatic step(input logic r, input logic [3:0] q, input logic [3:0] g, input logic p,
                       input string nm, input int n);
      rst = r;
      req = q;
      @(posedge clk);
      #1;
      check({nm, " gnt"},       n, {4'd0, gnt},       {4'd0, g});
      check({nm, " gnt_idx"},   n, {6'd0, gnt_idx},   {6'd0, onehot2idx(g)});
      check({nm, " gnt_valid"}, n, {7'd0, gnt_valid}, {7'd0, (g != 4'd0)});
      check({nm, " preempt"},   n, {7'd0, preempt},   {7'd0, p});
   endtask

   always @(negedge clk) begin
      if (inv_on) begin
         total++;
         if (!($onehot0(gnt) && (gnt_valid == (gnt != 4'd0)) &&
               (gnt_idx == onehot2idx(gnt)) && !(preempt && gnt_valid))) begin
            bad++;
            $display("FAIL invariant at %0t: gnt=%b idx=%0d valid=%b preempt=%b",
                     $time, gnt, gnt_idx, gnt_valid, preempt);
         end
      end
   end

   initial begin
      rst = 1'b1;
      req = 4'd0;

      // Reset values, held on every reset cycle even with requests present.
      add(1, 4'b0000, 4'b0000, 0);
      add(1, 4'b1111, 4'b0000, 0);
      // Single requester: grant one cycle after request, drop one cycle after release.
      add(0, 4'b0000, 4'b0000, 0);
      add(0, 4'b0001, 4'b0001, 0);
      add(0, 4'b0001, 4'b0001, 0);
      add(0, 4'b0001, 4'b0001, 0);
      add(0, 4'b0000, 4'b0000, 0);
      add(0, 4'b0000, 4'b0000, 0);
      // All four requesting, each releasing after two grant cycles: 0,1,2,3,0.
      add(1, 4'b0000, 4'b0000, 0);
      add(0, 4'b1111, 4'b0001, 0);
      add(0, 4'b1111, 4'b0001, 0);
      add(0, 4'b1110, 4'b0000, 0);
      add(0, 4'b1111, 4'b0010, 0);
      add(0, 4'b1111, 4'b0010, 0);
      add(0, 4'b1101, 4'b0000, 0);
      add(0, 4'b1111, 4'b0100, 0);
      add(0, 4'b1111, 4'b0100, 0);
      add(0, 4'b1011, 4'b0000, 0);
      add(0, 4'b1111, 4'b1000, 0);
      add(0, 4'b1111, 4'b1000, 0);
      add(0, 4'b0111, 4'b0000, 0);
      add(0, 4'b1111, 4'b0001, 0);
      add(0, 4'b1110, 4'b0000, 0);
      // Pointer skip: 1010 from ptr 0 -> idx 1, then from ptr 2 -> idx 3.
      add(1, 4'b0000, 4'b0000, 0);
      add(0, 4'b1010, 4'b0010, 0);
      add(0, 4'b0000, 4'b0000, 0);
      add(0, 4'b1010, 4'b1000, 0);
      add(0, 4'b0000, 4'b0000, 0);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].req, tbl[i].gnt, tbl[i].pre, "table", i);
         if (i == 1) inv_on = 1'b1;
      end

      // Preemption: idx 2 holds while idx 0 waits -> 8 grant cycles, pulse, then idx 0.
      step(1, 4'b0000, 4'b0000, 0, "preempt", 0);
      step(0, 4'b0100, 4'b0100, 0, "preempt", 1);
      for (int k = 0; k < 7; k++) step(0, 4'b0101, 4'b0100, 0, "preempt", 2 + k);
      step(0, 4'b0101, 4'b0000, 1, "preempt", 9);
      step(0, 4'b0101, 4'b0001, 0, "preempt", 10);
      step(0, 4'b0000, 4'b0000, 0, "preempt", 11);

      // Lone holder kept indefinitely; then release in a timeout-eligible cycle.
      step(1, 4'b0000, 4'b0000, 0, "longhold", 0);
      for (int k = 0; k < 21; k++) step(0, 4'b0100, 4'b0100, 0, "longhold", 1 + k);
      step(0, 4'b0001, 4'b0000, 0, "release_vs_timeout", 0);
      step(0, 4'b0001, 4'b0001, 0, "release_vs_timeout", 1);
      step(0, 4'b0000, 4'b0000, 0, "release_vs_timeout", 2);

      // Reset mid-tenure: grant drops without a pulse and returns after release.
      step(1, 4'b0000, 4'b0000, 0, "midreset", 0);
      step(0, 4'b1000, 4'b1000, 0, "midreset", 1);
      step(0, 4'b1000, 4'b1000, 0, "midreset", 2);
      step(1, 4'b1000, 4'b0000, 0, "midreset", 3);
      step(0, 4'b1000, 4'b1000, 0, "midreset", 4);
      step(0, 4'b0000, 4'b0000, 0, "midreset", 5);

      // Pointer returns to 0 on reset: after granting idx 1 (ptr 2), 0110 must pick idx 1.
      step(0, 4'b0010, 4'b0010, 0, "ptrreset", 0);
      step(1, 4'b0010, 4'b0000, 0, "ptrreset", 1);
      step(0, 4'b0110, 4'b0010, 0, "ptrreset", 2);
      step(0, 4'b0000, 4'b0000, 0, "ptrreset", 3);

      inv_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_arbiter4_enc.md
Name: rr_arbiter4_enc

Overview:
- Round-robin arbiter that shares one downstream resource between four requesters.
- Picks one request per arbitration and drives a one-hot grant plus its 2-bit encoded index (index 3 -> 2'b11, 2 -> 2'b10, 1 -> 2'b01, 0 -> 2'b00).
- Holds the grant for a multi-cycle tenure and can preempt a long tenure.
- Sits in front of any 4:1 shared datapath; gnt_idx drives the mux select directly.

Parameters:
- MAX_HOLD, 8: maximum tenure in cycles while other requests are pending; 0 disables preemption.
- HOLD_W, 4: width of the tenure counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request lines; req[i] stays high for the whole desired tenure.
- gnt  output  4  one-hot grant, registered; all zero when nothing is granted.
- gnt_idx  output  2  binary index of the granted line; 2'b00 when gnt_valid = 0.
- gnt_valid  output  1  high when any gnt bit is high.
- preempt  output  1  one-cycle pulse in the cycle the grant is withdrawn by the MAX_HOLD timeout.

Behaviour:
- Reset (rst = 1 at clk edge), same values held every reset cycle:
  - gnt = 0, gnt_idx = 0, gnt_valid = 0, preempt = 0.
  - state = IDLE, priority pointer ptr = 0, hold_cnt = 0.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - If req != 0, the winner is the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next cycle: gnt = onehot(winner), gnt_idx = winner, gnt_valid = 1, ptr = winner+1 (mod 4), hold_cnt = 0, state -> BUSY.
  - If req == 0, stay in IDLE; outputs stay 0.
- Latency: req rising in cycle N gives a grant visible in cycle N+1.
- BUSY, req[gnt_idx] == 0 (release):
  - Next cycle: gnt = 0, gnt_valid = 0, gnt_idx = 0, state -> IDLE.
  - Re-arbitration happens in IDLE, so there is a minimum 1-cycle gap with no grant between tenures.
- BUSY, req[gnt_idx] == 1:
  - hold_cnt increments, saturating at MAX_HOLD-1.
  - If MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1 and (req & ~gnt) != 0: next cycle gnt = 0, preempt = 1 for exactly that cycle, state -> IDLE.
  - Because ptr was already advanced at grant time, the preempted requester now has lowest priority.
  - If no other request is pending, the grant is kept indefinitely; the counter stays saturated.
- Tenure length: a preempted grant is high for exactly MAX_HOLD cycles.
- Simultaneous events: release takes precedence over preempt. If req[gnt_idx] drops in the timeout cycle, preempt stays 0.
- Non-granted req lines are don't-care while BUSY. Requests arriving mid-tenure wait for IDLE.
- Reset mid-tenure: grant drops on the next edge and ptr returns to 0. No preempt pulse is generated.
- Invariants the bench checks every cycle:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_idx == encode(gnt).
  - preempt implies gnt_valid == 0 in the same cycle.

Decomposition:
- Shared package arb_pkg holds:
  - state typedef {ARB_IDLE, ARB_BUSY};
  - localparam NREQ = 4 and IDX_W = 2;
  - function onehot2idx for the 4-to-2 encoding, which the bench also uses as its reference model.
- One sub-module, rr_pick4: combinational rotated priority encoder.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, win_idx[1:0].
  - Implemented as rotate, fixed-priority encode, add ptr mod 4.

Test Plan:
- Reset, then req = 4'b0001 at cycle 2 -> gnt = 4'b0001, gnt_idx = 2'b00, gnt_valid = 1 at cycle 3. req drops at cycle 5 -> gnt = 0 at cycle 6.
- From reset, req = 4'b1111 held, each requester releasing after 2 cycles of grant -> grants in order idx 0, 1, 2, 3, 0, with a 1-cycle gap between each.
- From ptr = 0, req = 4'b1010 -> grant idx 1 (2'b01), ptr = 2. Re-request 4'b1010 -> grant idx 3 (2'b11).
- MAX_HOLD = 8, req[2] held and req[0] asserted 1 cycle after grant -> gnt[2] high for 8 cycles; preempt = 1 in the cycle gnt drops to 0. Next cycle gnt = 4'b0001.
- req[2] held alone for 20 cycles -> gnt = 4'b0100 throughout, preempt never asserts.
- rst = 1 for one cycle during a tenure with req = 4'b1000 still high -> gnt = 0 and preempt = 0 after the reset edge; grant to idx 3 returns 1 cycle after rst is released, with ptr restarted from 0.
